axi4_addr_router: RTL and testbench
===================================

AXI4_ADDR_ROUTER -- requirements
Module: axi4_addr_router

Interface
REQ-001 Parameter NUM_SLAVES, default 2: number of downstream AXI4 ports, 1..8.
REQ-002 Parameter ADDR_WIDTH, default 32: address width.
REQ-003 Parameter DATA_WIDTH, default 64: data width; strobe width is DATA_WIDTH/8.
REQ-004 Parameter ID_WIDTH, default 4: ID width.
REQ-005 Parameter BASE, default {32'h6000_0000, 32'h8000_0000}: packed NUM_SLAVES*ADDR_WIDTH region bases; slave 0 occupies the least-significant slice.
REQ-006 Parameter MASK, default {32'hE000_0000, 32'h8000_0000}: packed NUM_SLAVES*ADDR_WIDTH region masks.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 rst  in  1  synchronous, active-low reset.
REQ-009 s_aw{valid,ready,id,addr,len,size,burst}  upstream AW  1/1/ID/ADDR/8/3/2  upstream write address; only ready is an output.
REQ-010 s_w{valid,ready,data,strb,last}  upstream W  1/1/DATA/DATA/8/1  upstream write data; only ready is an output.
REQ-011 s_b{valid,ready,id,resp}  upstream B  1/1/ID/2  upstream write response; only ready is an input.
REQ-012 s_ar{valid,ready,id,addr,len,size,burst}  upstream AR  widths as AW  upstream read address; only ready is an output.
REQ-013 s_r{valid,ready,id,data,resp,last}  upstream R  1/1/ID/DATA/2/1  upstream read data; only ready is an input.
REQ-014 m_* bundles carry the same five channels, each field NUM_SLAVES wide-packed, with directions mirrored relative to the s_* bundles.

Function
REQ-015 Slave i is hit when (addr & MASK[i]) == BASE[i]; on overlapping regions the lowest i wins; no hit selects the internal error target ERR.
REQ-016 The write FSM has states W_IDLE, W_DATA and W_RESP; the read FSM has states R_IDLE and R_DATA; the two FSMs are fully independent.
REQ-017 Each direction allows one outstanding transaction; s_awready is 0 outside W_IDLE and s_arready is 0 outside R_IDLE.
REQ-018 In W_IDLE: m_awvalid[t] = s_awvalid for the decoded target t (0-cycle pass-through); s_awready = m_awready[t], or 1 if the target is ERR.
REQ-019 On AW handshake: latch the target and awid; next state W_DATA.
REQ-020 In W_DATA: W is routed to the latched target only; for ERR, s_wready = 1 and the data is discarded; on a handshake with wlast = 1, next state W_RESP.
REQ-021 In W_RESP: B is routed from the target; for ERR, s_bvalid = 1, bid = latched id and bresp = 2'b11; on B handshake, next state W_IDLE.
REQ-022 On AR handshake: latch the target, arid and arlen; next state R_DATA.
REQ-023 In R_DATA: R is routed from the target, and the FSM returns to R_IDLE on a handshake with rlast = 1.
REQ-024 For an ERR read, the block itself drives arlen+1 beats with rdata = 0, rresp = 2'b11, rid = latched id, and rlast on the final beat only.
REQ-025 The ERR read beat counter is 8 bits and decrements only on handshake; arlen = 255 yields 256 beats with no wrap error.
REQ-026 Unselected m_*valid and m_*ready are 0; the payload fields of unselected ports are don't-care.
REQ-027 A W beat arriving before the AW handshake is not accepted (s_wready = 0 in W_IDLE).
REQ-028 An upstream valid held while the downstream ready is low stalls without state change.
REQ-029 AW and AR arriving on the same cycle are both accepted in that cycle, including when they target the same slave.

Reset
REQ-030 When rst = 0 at a rising edge, both FSMs go to IDLE and the ERR counter is cleared.
REQ-031 During reset and the cycle after it, all s_*valid, s_*ready, m_*valid and m_*ready outputs are 0.
REQ-032 A reset mid-transaction abandons the transaction without any further beat or response being issued.

Verification
REQ-033 Write a 4-beat burst (awlen = 3) to 0x8000_1000 -> only port 0 sees AW/W, port 1 sees nothing, and the upstream bresp equals port 0's bresp.
REQ-034 Read from 0x6000_0040 with arlen = 1 -> routed to port 1; 2 R beats are passed through with rlast on beat 2.
REQ-035 Write to 0x1000_0000 (unmapped) with awlen = 2 -> 3 W beats accepted, no m_awvalid asserted, one B with bresp = 2'b11 and bid equal to awid.
REQ-036 Read from 0x0 (unmapped) with arlen = 255 -> 256 R beats with rresp = 2'b11 and rdata = 0, rlast only on beat 256, with random s_rready backpressure.
REQ-037 Issue a second AW while the first is in W_DATA -> s_awready = 0 until the first B handshake completes.
REQ-038 Assert rst = 0 during beat 2 of a 4-beat read -> the next cycle has all valids at 0, and a new AR is accepted in R_IDLE.

Source files
------------

// File: rtl/axi4_addr_router_if.sv
// AXI4 five-channel bundle; every field is N ports wide, packed with port 0 in the
// least-significant slice. N = 1 gives a plain single-port AXI4 bus.
interface axi4_addr_router_if #(
    parameter int N          = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    logic [N-1:0]              awvalid, awready;
    logic [N*ID_WIDTH-1:0]     awid;
    logic [N*ADDR_WIDTH-1:0]   awaddr;
    logic [N*8-1:0]            awlen;
    logic [N*3-1:0]            awsize;
    logic [N*2-1:0]            awburst;

    logic [N-1:0]              wvalid, wready, wlast;
    logic [N*DATA_WIDTH-1:0]   wdata;
    logic [N*DATA_WIDTH/8-1:0] wstrb;

    logic [N-1:0]              bvalid, bready;
    logic [N*ID_WIDTH-1:0]     bid;
    logic [N*2-1:0]            bresp;

    logic [N-1:0]              arvalid, arready;
    logic [N*ID_WIDTH-1:0]     arid;
    logic [N*ADDR_WIDTH-1:0]   araddr;
    logic [N*8-1:0]            arlen;
    logic [N*3-1:0]            arsize;
    logic [N*2-1:0]            arburst;

    logic [N-1:0]              rvalid, rready, rlast;
    logic [N*ID_WIDTH-1:0]     rid;
    logic [N*DATA_WIDTH-1:0]   rdata;
    logic [N*2-1:0]            rresp;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input  bvalid, bid, bresp, output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst, input arready,
        input  rvalid, rid, rdata, rresp, rlast, output rready
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst, output awready,
        input  wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bid, bresp, input bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst, output arready,
        output rvalid, rid, rdata, rresp, rlast, input rready
    );
endinterface

// File: rtl/axi4_addr_router.sv
// One-to-NUM_SLAVES AXI4 address router: one outstanding write and one outstanding read,
// unmapped addresses answered internally with DECERR.
module axi4_addr_router #(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE = {32'h6000_0000, 32'h8000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] MASK = {32'hE000_0000, 32'h8000_0000}
) (
    input  logic               clk,
    input  logic               rst,
    axi4_addr_router_if.slave  s,
    axi4_addr_router_if.master m
);
    localparam int TW = $clog2(NUM_SLAVES + 1);
    localparam logic [TW-1:0] ERR = TW'(NUM_SLAVES);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Lowest matching index wins, so scan downwards and let later hits overwrite.
    function automatic logic [TW-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [TW-1:0] t;
        t = ERR;
        for (int i = NUM_SLAVES - 1; i >= 0; i--)
            if ((addr & MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == BASE[i*ADDR_WIDTH +: ADDR_WIDTH])
                t = TW'(i);
        return t;
    endfunction

    logic out_en, active;
    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;
    logic [TW-1:0] aw_tgt, ar_tgt, w_tgt, r_tgt;
    logic [ID_WIDTH-1:0] w_id, r_id_q;
    logic [7:0] r_cnt;

    logic [NUM_SLAVES-1:0] m_awvalid_c, m_wvalid_c, m_bready_c, m_arvalid_c, m_rready_c;
    logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld, r_lst, err_r_hs;
    logic [ID_WIDTH-1:0] b_id, r_id;
    logic [1:0] b_resp, r_resp;
    logic [DATA_WIDTH-1:0] r_data;

    assign aw_tgt = decode(s.awaddr);
    assign ar_tgt = decode(s.araddr);
    // Handshake outputs stay low while in reset and for the first cycle after it.
    assign active = rst & out_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_en  <= 1'b0;
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            out_en  <= 1'b1;
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
            if (s.arvalid && ar_rdy)
                r_cnt <= s.arlen;
            else if (err_r_hs && r_cnt != 8'd0)
                r_cnt <= r_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (s.awvalid && aw_rdy) begin
            w_tgt <= aw_tgt;
            w_id  <= s.awid;
        end
        if (s.arvalid && ar_rdy) begin
            r_tgt  <= ar_tgt;
            r_id_q <= s.arid;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        m_awvalid_c = '0;
        m_wvalid_c  = '0;
        m_bready_c  = '0;
        aw_rdy      = 1'b0;
        w_rdy       = 1'b0;
        b_vld       = 1'b0;
        b_id        = '0;
        b_resp      = 2'b00;
        if (active) begin
            case (w_state)
                W_IDLE: begin
                    if (aw_tgt == ERR) aw_rdy = 1'b1;
                    for (int i = 0; i < NUM_SLAVES; i++)
                        if (aw_tgt == TW'(i)) begin
                            m_awvalid_c[i] = s.awvalid;
                            aw_rdy         = m.awready[i];
                        end
                    if (s.awvalid && aw_rdy) w_state_nxt = W_DATA;
                end
                W_DATA: begin
                    // Beats for an unmapped write are swallowed.
                    if (w_tgt == ERR) w_rdy = 1'b1;
                    for (int i = 0; i < NUM_SLAVES; i++)
                        if (w_tgt == TW'(i)) begin
                            m_wvalid_c[i] = s.wvalid;
                            w_rdy         = m.wready[i];
                        end
                    if (s.wvalid && w_rdy && s.wlast) w_state_nxt = W_RESP;
                end
                W_RESP: begin
                    if (w_tgt == ERR) begin
                        b_vld  = 1'b1;
                        b_id   = w_id;
                        b_resp = 2'b11;
                    end
                    for (int i = 0; i < NUM_SLAVES; i++)
                        if (w_tgt == TW'(i)) begin
                            m_bready_c[i] = s.bready;
                            b_vld         = m.bvalid[i];
                            b_id          = m.bid[i*ID_WIDTH +: ID_WIDTH];
                            b_resp        = m.bresp[i*2 +: 2];
                        end
                    if (b_vld && s.bready) w_state_nxt = W_IDLE;
                end
                default: w_state_nxt = W_IDLE;
            endcase
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        m_arvalid_c = '0;
        m_rready_c  = '0;
        ar_rdy      = 1'b0;
        r_vld       = 1'b0;
        r_lst       = 1'b0;
        r_id        = '0;
        r_data      = '0;
        r_resp      = 2'b00;
        err_r_hs    = 1'b0;
        if (active) begin
            case (r_state)
                R_IDLE: begin
                    if (ar_tgt == ERR) ar_rdy = 1'b1;
                    for (int i = 0; i < NUM_SLAVES; i++)
                        if (ar_tgt == TW'(i)) begin
                            m_arvalid_c[i] = s.arvalid;
                            ar_rdy         = m.arready[i];
                        end
                    if (s.arvalid && ar_rdy) r_state_nxt = R_DATA;
                end
                R_DATA: begin
                    // Unmapped read: generate arlen+1 zero beats, counting down to the last.
                    if (r_tgt == ERR) begin
                        r_vld    = 1'b1;
                        r_id     = r_id_q;
                        r_resp   = 2'b11;
                        r_lst    = (r_cnt == 8'd0);
                        err_r_hs = s.rready;
                    end
                    for (int i = 0; i < NUM_SLAVES; i++)
                        if (r_tgt == TW'(i)) begin
                            m_rready_c[i] = s.rready;
                            r_vld         = m.rvalid[i];
                            r_id          = m.rid[i*ID_WIDTH +: ID_WIDTH];
                            r_data        = m.rdata[i*DATA_WIDTH +: DATA_WIDTH];
                            r_resp        = m.rresp[i*2 +: 2];
                            r_lst         = m.rlast[i];
                        end
                    if (r_vld && s.rready && r_lst) r_state_nxt = R_IDLE;
                end
                default: r_state_nxt = R_IDLE;
            endcase
        end
    end

    assign s.awready = aw_rdy;
    assign s.wready  = w_rdy;
    assign s.bvalid  = b_vld;
    assign s.bid     = b_id;
    assign s.bresp   = b_resp;
    assign s.arready = ar_rdy;
    assign s.rvalid  = r_vld;
    assign s.rid     = r_id;
    assign s.rdata   = r_data;
    assign s.rresp   = r_resp;
    assign s.rlast   = r_lst;

    assign m.awvalid = m_awvalid_c;
    assign m.wvalid  = m_wvalid_c;
    assign m.bready  = m_bready_c;
    assign m.arvalid = m_arvalid_c;
    assign m.rready  = m_rready_c;

    // Payloads are broadcast; only the selected port sees a valid.
    assign m.awid    = {NUM_SLAVES{s.awid}};
    assign m.awaddr  = {NUM_SLAVES{s.awaddr}};
    assign m.awlen   = {NUM_SLAVES{s.awlen}};
    assign m.awsize  = {NUM_SLAVES{s.awsize}};
    assign m.awburst = {NUM_SLAVES{s.awburst}};
    assign m.wdata   = {NUM_SLAVES{s.wdata}};
    assign m.wstrb   = {NUM_SLAVES{s.wstrb}};
    assign m.wlast   = {NUM_SLAVES{s.wlast}};
    assign m.arid    = {NUM_SLAVES{s.arid}};
    assign m.araddr  = {NUM_SLAVES{s.araddr}};
    assign m.arlen   = {NUM_SLAVES{s.arlen}};
    assign m.arsize  = {NUM_SLAVES{s.arsize}};
    assign m.arburst = {NUM_SLAVES{s.arburst}};
endmodule

// File: tb/tb_axi4_addr_router.sv
// Bench for axi4_addr_router: directed scenarios plus random traffic against two
// behavioural AXI4 slaves and an address-map reference model.
module tb_axi4_addr_router;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi4_addr_router_if #(.N(1)) up ();
    axi4_addr_router_if #(.N(2)) dn ();

    axi4_addr_router dut (.clk(clk), .rst(rst), .s(up), .m(dn));

    int compared = 0;
    int mismatched = 0;

    localparam logic [31:0] MAP_BASE [2] = '{32'h8000_0000, 32'h6000_0000};
    localparam logic [31:0] MAP_MASK [2] = '{32'h8000_0000, 32'hE000_0000};

    function automatic int exp_target(input logic [31:0] addr);
        for (int i = 0; i < 2; i++)
            if ((addr & MAP_MASK[i]) == MAP_BASE[i]) return i;
        return 2;
    endfunction

    function automatic logic [63:0] exp_rdata(input int p, input logic [7:0] beat);
        return 64'hA5A5_0000_0000_0000 | (64'(p) << 32) | 64'(beat);
    endfunction

    // Behavioural downstream slaves
    logic [1:0] sl_awready, sl_wready, sl_arready, sl_bvalid, sl_rvalid, sl_rlast;
    logic [3:0] sl_bid [2], sl_rid [2], sl_pend_id [2];
    logic [1:0] sl_bresp [2];
    logic [7:0] sl_rbeat [2], sl_rlen [2];
    int aw_seen [2], w_seen [2], ar_seen [2], r_sent [2], vld_cycles [2];
    logic [31:0] last_awaddr [2];
    logic [63:0] last_wdata [2];
    logic [1:0] resp_sel [2];
    bit force_ready = 1'b0;

    assign dn.awready = sl_awready;
    assign dn.wready  = sl_wready;
    assign dn.arready = sl_arready;
    assign dn.bvalid  = sl_bvalid;
    assign dn.bid     = {sl_bid[1], sl_bid[0]};
    assign dn.bresp   = {sl_bresp[1], sl_bresp[0]};
    assign dn.rvalid  = sl_rvalid;
    assign dn.rlast   = sl_rlast;
    assign dn.rid     = {sl_rid[1], sl_rid[0]};
    assign dn.rdata   = {exp_rdata(1, sl_rbeat[1]), exp_rdata(0, sl_rbeat[0])};
    assign dn.rresp   = {2'b01, 2'b00};

    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            sl_awready[p] <= force_ready || ($urandom_range(0, 2) != 0);
            sl_wready[p]  <= force_ready || ($urandom_range(0, 2) != 0);
            sl_arready[p] <= force_ready || ($urandom_range(0, 2) != 0);
            if (dn.awvalid[p] || dn.wvalid[p] || dn.arvalid[p]) vld_cycles[p] <= vld_cycles[p] + 1;
            if (dn.awvalid[p] && dn.awready[p]) begin
                aw_seen[p]     <= aw_seen[p] + 1;
                last_awaddr[p] <= dn.awaddr[p*32 +: 32];
                sl_pend_id[p]  <= dn.awid[p*4 +: 4];
            end
            if (sl_bvalid[p] && dn.bready[p]) sl_bvalid[p] <= 1'b0;
            if (dn.wvalid[p] && dn.wready[p]) begin
                w_seen[p]     <= w_seen[p] + 1;
                last_wdata[p] <= dn.wdata[p*64 +: 64];
                if (dn.wlast[p]) begin
                    sl_bvalid[p] <= 1'b1;
                    sl_bid[p]    <= sl_pend_id[p];
                    sl_bresp[p]  <= resp_sel[p];
                end
            end
            if (dn.arvalid[p] && dn.arready[p]) begin
                ar_seen[p]   <= ar_seen[p] + 1;
                sl_rvalid[p] <= 1'b1;
                sl_rid[p]    <= dn.arid[p*4 +: 4];
                sl_rbeat[p]  <= 8'd0;
                sl_rlen[p]   <= dn.arlen[p*8 +: 8];
                sl_rlast[p]  <= (dn.arlen[p*8 +: 8] == 8'd0);
            end else if (sl_rvalid[p] && dn.rready[p]) begin
                r_sent[p] <= r_sent[p] + 1;
                if (sl_rlast[p]) sl_rvalid[p] <= 1'b0;
                else begin
                    sl_rbeat[p] <= sl_rbeat[p] + 8'd1;
                    sl_rlast[p] <= ((sl_rbeat[p] + 8'd1) == sl_rlen[p]);
                end
            end
            if (!rst) begin
                sl_bvalid[p] <= 1'b0;
                sl_rvalid[p] <= 1'b0;
                sl_rlast[p]  <= 1'b0;
            end
        end
    end

    wire [14:0] hs_outs = {up.awready, up.wready, up.bvalid, up.arready, up.rvalid,
                           dn.awvalid, dn.wvalid, dn.bready, dn.arvalid, dn.rready};

    logic [63:0] q_data [$];
    logic [1:0]  q_resp [$];
    logic [3:0]  q_id [$];
    bit          q_last [$];

    // Upstream master drivers; every wait is bounded and reports ok = 0 on timeout
    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id, output bit ok);
        bit got;
        up.awvalid = 1'b1; up.awaddr = addr; up.awlen = len; up.awid = id;
        up.awsize = 3'd3; up.awburst = 2'b01; ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1 got = up.awready;
            @(negedge clk);
            if (got) begin ok = 1'b1; break; end
        end
        up.awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id, output bit ok);
        bit got;
        up.arvalid = 1'b1; up.araddr = addr; up.arlen = len; up.arid = id;
        up.arsize = 3'd3; up.arburst = 2'b01; ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1 got = up.arready;
            @(negedge clk);
            if (got) begin ok = 1'b1; break; end
        end
        up.arvalid = 1'b0;
    endtask

    task automatic send_w(input logic [7:0] len, output bit ok, output logic [63:0] last_d);
        bit got;
        ok = 1'b1;
        last_d = '0;
        for (int b = 0; b <= int'(len); b++) begin
            up.wvalid = 1'b1; up.wdata = {$urandom, $urandom}; up.wstrb = '1;
            up.wlast = (b == int'(len)); last_d = up.wdata; got = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                #1 got = up.wready;
                @(negedge clk);
            end
            if (!got) ok = 1'b0;
        end
        up.wvalid = 1'b0; up.wlast = 1'b0;
    endtask

    task automatic recv_b(output logic [3:0] id, output logic [1:0] resp, output bit ok);
        bit got;
        up.bready = 1'b1; ok = 1'b0; id = '0; resp = '0;
        for (int c = 0; c < 200; c++) begin
            #1 got = up.bvalid; id = up.bid; resp = up.bresp;
            @(negedge clk);
            if (got) begin ok = 1'b1; break; end
        end
        up.bready = 1'b0;
    endtask

    task automatic recv_r(input bit rnd, input int beats, output bit ok);
        bit got, lst;
        q_data.delete(); q_resp.delete(); q_id.delete(); q_last.delete();
        ok = 1'b0;
        for (int c = 0; c < beats * 8 + 100; c++) begin
            up.rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1 got = up.rvalid && up.rready; lst = up.rlast;
            if (got) begin
                q_data.push_back(up.rdata); q_resp.push_back(up.rresp);
                q_id.push_back(up.rid); q_last.push_back(up.rlast);
            end
            @(negedge clk);
            if (got && lst) begin ok = 1'b1; break; end
        end
        up.rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        up.awvalid = 1'b1; up.awaddr = 32'h1000_0000; up.arvalid = 1'b1; up.araddr = 32'h0;
        up.wvalid = 1'b1; up.wlast = 1'b0; up.bready = 1'b1; up.rready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        compared++; if (hs_outs !== 15'h0) begin mismatched++; $display("FAIL reset_outputs: got %h want 0", hs_outs); end
        rst = 1'b1;
        #1;
        compared++; if (hs_outs !== 15'h0) begin mismatched++; $display("FAIL post_reset_cycle: got %h want 0", hs_outs); end
        @(negedge clk); #1;
        compared++; if (up.awready !== 1'b1) begin mismatched++; $display("FAIL idle_err_awready: got %b want 1", up.awready); end
        compared++; if (up.arready !== 1'b1) begin mismatched++; $display("FAIL idle_err_arready: got %b want 1", up.arready); end
        compared++; if (up.wready !== 1'b0) begin mismatched++; $display("FAIL early_w_blocked: got %b want 0", up.wready); end
        up.awvalid = 1'b0; up.arvalid = 1'b0; up.wvalid = 1'b0; up.bready = 1'b0; up.rready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_slave0();
        bit ok1, ok2, ok3; logic [63:0] ld; logic [3:0] id, bid; logic [1:0] br;
        int a0, w0, v1;
        a0 = aw_seen[0]; w0 = w_seen[0]; v1 = vld_cycles[1];
        resp_sel[0] = 2'($urandom_range(0, 1)); id = 4'($urandom);
        send_aw(32'h8000_1000, 8'd3, id, ok1);
        send_w(8'd3, ok2, ld);
        recv_b(bid, br, ok3);
        compared++; if ({ok1, ok2, ok3} !== 3'b111) begin mismatched++; $display("FAIL wr0_handshakes: got %b want 111", {ok1, ok2, ok3}); end
        compared++; if (aw_seen[0] - a0 !== 1) begin mismatched++; $display("FAIL wr0_aw_count: got %0d want 1", aw_seen[0] - a0); end
        compared++; if (w_seen[0] - w0 !== 4) begin mismatched++; $display("FAIL wr0_w_beats: got %0d want 4", w_seen[0] - w0); end
        compared++; if (vld_cycles[1] - v1 !== 0) begin mismatched++; $display("FAIL wr0_port1_quiet: got %0d want 0", vld_cycles[1] - v1); end
        compared++; if (last_awaddr[0] !== 32'h8000_1000) begin mismatched++; $display("FAIL wr0_awaddr: got %h want 80001000", last_awaddr[0]); end
        compared++; if (last_wdata[0] !== ld) begin mismatched++; $display("FAIL wr0_wdata: got %h want %h", last_wdata[0], ld); end
        compared++; if (br !== resp_sel[0]) begin mismatched++; $display("FAIL wr0_bresp: got %0d want %0d", br, resp_sel[0]); end
        compared++; if (bid !== id) begin mismatched++; $display("FAIL wr0_bid: got %0h want %0h", bid, id); end
    endtask

    task automatic test_read_slave1();
        bit ok1, ok2; logic [3:0] id; int a1, v0;
        a1 = ar_seen[1]; v0 = vld_cycles[0]; id = 4'($urandom);
        send_ar(32'h6000_0040, 8'd1, id, ok1);
        recv_r(1'b0, 2, ok2);
        compared++; if ({ok1, ok2} !== 2'b11) begin mismatched++; $display("FAIL rd1_handshakes: got %b want 11", {ok1, ok2}); end
        compared++; if (q_data.size() !== 2) begin mismatched++; $display("FAIL rd1_beats: got %0d want 2", q_data.size()); end
        compared++; if ({q_last[0], q_last[1]} !== 2'b01) begin mismatched++; $display("FAIL rd1_rlast: got %b want 01", {q_last[0], q_last[1]}); end
        compared++; if (q_data[1] !== exp_rdata(1, 8'd1)) begin mismatched++; $display("FAIL rd1_rdata: got %h want %h", q_data[1], exp_rdata(1, 8'd1)); end
        compared++; if (q_resp[0] !== 2'b01 || q_id[1] !== id) begin mismatched++; $display("FAIL rd1_resp_id: got %0d/%0h want 1/%0h", q_resp[0], q_id[1], id); end
        compared++; if (ar_seen[1] - a1 !== 1 || vld_cycles[0] !== v0) begin mismatched++; $display("FAIL rd1_routing: got ar1 %0d port0 %0d want 1/0", ar_seen[1] - a1, vld_cycles[0] - v0); end
    endtask

    task automatic test_write_err();
        bit ok1, ok2, ok3; logic [63:0] ld; logic [3:0] id, bid; logic [1:0] br; int v;
        v = vld_cycles[0] + vld_cycles[1]; id = 4'($urandom);
        send_aw(32'h1000_0000, 8'd2, id, ok1);
        send_w(8'd2, ok2, ld);
        recv_b(bid, br, ok3);
        compared++; if ({ok1, ok2, ok3} !== 3'b111) begin mismatched++; $display("FAIL wrerr_handshakes: got %b want 111", {ok1, ok2, ok3}); end
        compared++; if (vld_cycles[0] + vld_cycles[1] - v !== 0) begin mismatched++; $display("FAIL wrerr_no_downstream: got %0d want 0", vld_cycles[0] + vld_cycles[1] - v); end
        compared++; if (br !== 2'b11) begin mismatched++; $display("FAIL wrerr_bresp: got %0d want 3", br); end
        compared++; if (bid !== id) begin mismatched++; $display("FAIL wrerr_bid: got %0h want %0h", bid, id); end
    endtask

    task automatic test_read_err_long();
        bit ok1, ok2; logic [3:0] id; int bad, lasts;
        id = 4'($urandom); bad = 0; lasts = 0;
        send_ar(32'h0, 8'd255, id, ok1);
        recv_r(1'b1, 256, ok2);
        for (int i = 0; i < q_data.size(); i++) begin
            if (q_data[i] !== 64'h0 || q_resp[i] !== 2'b11 || q_id[i] !== id) bad++;
            if (q_last[i]) lasts++;
        end
        compared++; if ({ok1, ok2} !== 2'b11) begin mismatched++; $display("FAIL rderr_handshakes: got %b want 11", {ok1, ok2}); end
        compared++; if (q_data.size() !== 256) begin mismatched++; $display("FAIL rderr_beats: got %0d want 256", q_data.size()); end
        compared++; if (bad !== 0) begin mismatched++; $display("FAIL rderr_payload: got %0d bad beats want 0", bad); end
        compared++; if (lasts !== 1 || q_last[255] !== 1'b1) begin mismatched++; $display("FAIL rderr_rlast: got %0d lasts want 1 on beat 256", lasts); end
    endtask

    task automatic test_aw_blocking();
        bit ok1, ok2, ok3, ok4, ok5; logic [63:0] ld; logic [3:0] id1, id2, bid; logic [1:0] br;
        resp_sel[0] = 2'b00; id1 = 4'($urandom); id2 = ~id1;
        send_aw(32'h8000_2000, 8'd1, id1, ok1);
        up.awvalid = 1'b1; up.awaddr = 32'h1000_0000; up.awlen = 8'd0; up.awid = id2;
        #1;
        compared++; if (up.awready !== 1'b0) begin mismatched++; $display("FAIL blk_awready_wdata: got %b want 0", up.awready); end
        @(negedge clk);
        send_w(8'd1, ok2, ld);
        #1;
        compared++; if (up.awready !== 1'b0) begin mismatched++; $display("FAIL blk_awready_wresp: got %b want 0", up.awready); end
        @(negedge clk);
        recv_b(bid, br, ok3);
        #1;
        compared++; if (up.awready !== 1'b1) begin mismatched++; $display("FAIL blk_awready_after_b: got %b want 1", up.awready); end
        @(negedge clk);
        up.awvalid = 1'b0;
        send_w(8'd0, ok4, ld);
        recv_b(bid, br, ok5);
        compared++; if ({ok1, ok2, ok3, ok4, ok5} !== 5'h1F) begin mismatched++; $display("FAIL blk_handshakes: got %b want 11111", {ok1, ok2, ok3, ok4, ok5}); end
        compared++; if (br !== 2'b11 || bid !== id2) begin mismatched++; $display("FAIL blk_second_b: got %0d/%0h want 3/%0h", br, bid, id2); end
    endtask

    task automatic test_same_cycle();
        bit ok1, ok2, ok3; logic [63:0] ld; logic [3:0] bid; logic [1:0] br; int a1, r1;
        a1 = aw_seen[1]; r1 = ar_seen[1];
        force_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        up.awvalid = 1'b1; up.awaddr = 32'h6000_0100; up.awlen = 8'd0; up.awid = 4'h5;
        up.arvalid = 1'b1; up.araddr = 32'h6000_0200; up.arlen = 8'd0; up.arid = 4'hA;
        #1;
        compared++; if ({up.awready, up.arready} !== 2'b11) begin mismatched++; $display("FAIL same_cycle_ready: got %b want 11", {up.awready, up.arready}); end
        @(negedge clk);
        up.awvalid = 1'b0; up.arvalid = 1'b0;
        send_w(8'd0, ok1, ld);
        recv_b(bid, br, ok2);
        recv_r(1'b0, 1, ok3);
        compared++; if (aw_seen[1] - a1 !== 1 || ar_seen[1] - r1 !== 1) begin mismatched++; $display("FAIL same_cycle_accept: got aw %0d ar %0d want 1/1", aw_seen[1] - a1, ar_seen[1] - r1); end
        compared++; if ({ok1, ok2, ok3} !== 3'b111 || q_data[0] !== exp_rdata(1, 8'd0) || bid !== 4'h5) begin mismatched++; $display("FAIL same_cycle_complete: got %b %h %0h want 111 %h 5", {ok1, ok2, ok3}, q_data[0], bid, exp_rdata(1, 8'd0)); end
        force_ready = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        bit ok1, ok2, got; logic [3:0] id2; int rs;
        force_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        send_ar(32'h8000_0300, 8'd3, 4'h3, ok1);
        up.rready = 1'b1; got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            #1 got = up.rvalid;
            @(negedge clk);
        end
        #1;
        compared++; if ({ok1, got, up.rvalid} !== 3'b111) begin mismatched++; $display("FAIL rstmid_beat2_present: got %b want 111", {ok1, got, up.rvalid}); end
        rst = 1'b0; rs = r_sent[0];
        #1;
        compared++; if (hs_outs !== 15'h0) begin mismatched++; $display("FAIL rstmid_outputs: got %h want 0", hs_outs); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        compared++; if (hs_outs !== 15'h0) begin mismatched++; $display("FAIL rstmid_next_cycle: got %h want 0", hs_outs); end
        compared++; if (r_sent[0] !== rs) begin mismatched++; $display("FAIL rstmid_no_extra_beat: got %0d want %0d", r_sent[0], rs); end
        @(negedge clk);
        up.rready = 1'b0; id2 = 4'hC;
        send_ar(32'h6000_0000, 8'd0, id2, ok1);
        recv_r(1'b0, 1, ok2);
        compared++; if ({ok1, ok2} !== 2'b11 || q_data.size() !== 1 || q_data[0] !== exp_rdata(1, 8'd0) || q_id[0] !== id2) begin mismatched++; $display("FAIL rstmid_new_ar: got %b n=%0d %h id %0h", {ok1, ok2}, q_data.size(), q_data[0], q_id[0]); end
        force_ready = 1'b0;
    endtask

    task automatic test_random();
        bit ok1, ok2, ok3; logic [63:0] ld; logic [31:0] addr; logic [7:0] len; logic [3:0] id, bid;
        logic [1:0] br, want_resp; int t, bad, aw_s [2], w_s [2], ar_s [2];
        for (int n = 0; n < 40; n++) begin
            addr = $urandom; len = 8'($urandom_range(0, 7)); id = 4'($urandom); t = exp_target(addr);
            for (int p = 0; p < 2; p++) begin
                aw_s[p] = aw_seen[p]; w_s[p] = w_seen[p]; ar_s[p] = ar_seen[p];
                resp_sel[p] = 2'($urandom_range(0, 1));
            end
            bad = 0;
            if ($urandom_range(0, 1) == 1) begin
                send_aw(addr, len, id, ok1);
                send_w(len, ok2, ld);
                recv_b(bid, br, ok3);
                for (int p = 0; p < 2; p++) begin
                    if (aw_seen[p] - aw_s[p] != ((t == p) ? 1 : 0)) bad++;
                    if (w_seen[p] - w_s[p] != ((t == p) ? int'(len) + 1 : 0)) bad++;
                end
                want_resp = (t == 2) ? 2'b11 : resp_sel[t];
                compared++; if ({ok1, ok2, ok3} !== 3'b111 || bad !== 0) begin mismatched++; $display("FAIL rand_wr_route: addr %h got ok %b bad %0d want 111/0", addr, {ok1, ok2, ok3}, bad); end
                compared++; if (br !== want_resp || bid !== id) begin mismatched++; $display("FAIL rand_wr_b: addr %h got %0d/%0h want %0d/%0h", addr, br, bid, want_resp, id); end
            end else begin
                send_ar(addr, len, id, ok1);
                recv_r(1'b1, int'(len) + 1, ok2);
                for (int p = 0; p < 2; p++)
                    if (ar_seen[p] - ar_s[p] != ((t == p) ? 1 : 0)) bad++;
                for (int i = 0; i < q_data.size(); i++) begin
                    if (q_data[i] !== ((t == 2) ? 64'h0 : exp_rdata(t, 8'(i)))) bad++;
                    if (q_resp[i] !== ((t == 2) ? 2'b11 : 2'(t))) bad++;
                    if (q_id[i] !== id || q_last[i] !== (i == int'(len))) bad++;
                end
                compared++; if ({ok1, ok2} !== 2'b11 || q_data.size() !== int'(len) + 1) begin mismatched++; $display("FAIL rand_rd_beats: addr %h got ok %b n=%0d want 11 n=%0d", addr, {ok1, ok2}, q_data.size(), int'(len) + 1); end
                compared++; if (bad !== 0) begin mismatched++; $display("FAIL rand_rd_payload: addr %h got %0d bad fields want 0", addr, bad); end
            end
        end
    endtask

    initial begin
        up.awvalid = 1'b0; up.awid = '0; up.awaddr = '0; up.awlen = '0; up.awsize = '0; up.awburst = '0;
        up.wvalid = 1'b0; up.wdata = '0; up.wstrb = '0; up.wlast = 1'b0; up.bready = 1'b0;
        up.arvalid = 1'b0; up.arid = '0; up.araddr = '0; up.arlen = '0; up.arsize = '0; up.arburst = '0;
        up.rready = 1'b0;
        resp_sel[0] = 2'b00; resp_sel[1] = 2'b00;
        @(negedge clk);
        test_reset();
        test_write_slave0();
        test_read_slave1();
        test_write_err();
        test_read_err_long();
        test_aw_blocking();
        test_same_cycle();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
